kd_nearest_search: RTL and testbench

Sequential nearest-center search engine that reads the cluster-center kd-tree after the compare-exchange sorting network has ordered it. It takes one query point per handshake and walks the tree root-to-leaf through a single-port node memory with one-cycle read latency. At each level it compares along that level's axis, computes the Manhattan distance to each visited center, and returns the best center, its heap index and its distance. It sits between the tree storage and the k-means assignment stage.

---
 rtl/kd_nearest_search.sv | 148 ++++++++++++++
 tb/tb_kd_nearest_search.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/kd_nearest_search.sv
// kd_nearest_search: greedy root-to-leaf nearest-center search over a heap-ordered
// kd-tree held in a single-port node memory with one-cycle read latency.
// Optional feature: define KD_SEARCH_STATS_EN to add the 16-bit search_count port.
module kd_nearest_search #(
  parameter int unsigned dim        = 3,
  parameter int unsigned data_range = 255,
  parameter int unsigned depth      = 3,
  localparam int unsigned dim_size    = $clog2(data_range),
  localparam int unsigned center_size = dim * dim_size,
  localparam int unsigned dist_size   = $clog2(data_range * dim),
  localparam int unsigned axis_size   = (dim > 1) ? $clog2(dim) : 1,
  localparam int unsigned nodes       = 2**depth - 1,
  localparam int unsigned idx_size    = (nodes > 1) ? $clog2(nodes) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [center_size-1:0] point_in,
  output logic                   node_rd,
  output logic [idx_size-1:0]    node_addr,
  input  logic [center_size-1:0] node_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [idx_size-1:0]    best_idx,
  output logic [center_size-1:0] best_center,
  output logic [dist_size-1:0]   best_dist
`ifdef KD_SEARCH_STATS_EN
  ,
  output logic [15:0]            search_count
`endif
);

  localparam int unsigned first_leaf = 2**(depth-1) - 1;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [center_size-1:0] point_q;
  logic [idx_size-1:0]    idx_q;
  logic [axis_size-1:0]   axis_q;

  logic [dist_size-1:0]   dist_c;
  logic [dim_size-1:0]    sel_p_c, sel_c_c;
  logic [dim_size-1:0]    pa_c, ca_c;
  logic [idx_size-1:0]    child_c;
  logic [axis_size-1:0]   axis_next_c;
  logic                   is_leaf_c;
  logic                   accept_c;

  // Manhattan distance to the current node and the split coordinates on this level's axis
  always_comb begin
    dist_c  = '0;
    sel_p_c = '0;
    sel_c_c = '0;
    pa_c    = '0;
    ca_c    = '0;
    for (int a = 0; a < dim; a++) begin
      pa_c   = point_q[a*dim_size +: dim_size];
      ca_c   = node_data[a*dim_size +: dim_size];
      dist_c = dist_c + dist_size'((pa_c >= ca_c) ? (pa_c - ca_c) : (ca_c - pa_c));
      if (axis_q == axis_size'(a)) begin
        sel_p_c = pa_c;
        sel_c_c = ca_c;
      end
    end
  end

  // Descent direction, axis rotation and leaf detection
  always_comb begin
    child_c     = (sel_p_c <= sel_c_c) ? ((idx_q << 1) + idx_size'(1))
                                       : ((idx_q << 1) + idx_size'(2));
    axis_next_c = (axis_q == axis_size'(dim - 1)) ? '0 : axis_q + axis_size'(1);
    is_leaf_c   = (idx_q >= idx_size'(first_leaf));
    accept_c    = in_valid && in_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = FETCH;
      FETCH:   state_d = EVAL;
      EVAL:    state_d = is_leaf_c ? DONE : FETCH;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake/strobe outputs, search context and best-so-far tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      node_rd     <= 1'b0;
      node_addr   <= '0;
      point_q     <= '0;
      idx_q       <= '0;
      axis_q      <= '0;
      best_idx    <= '0;
      best_center <= '0;
      best_dist   <= '0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      node_rd   <= (state_d == FETCH);
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            point_q   <= point_in;
            idx_q     <= '0;
            axis_q    <= '0;
            node_addr <= '0;
          end
        end
        EVAL: begin
          // Root loads unconditionally; deeper nodes must be strictly closer
          if (idx_q == '0 || dist_c < best_dist) begin
            best_idx    <= idx_q;
            best_center <= node_data;
            best_dist   <= dist_c;
          end
          if (!is_leaf_c) begin
            idx_q     <= child_c;
            axis_q    <= axis_next_c;
            node_addr <= child_c;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KD_SEARCH_STATS_EN
  // Completed-search counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (rst)                         search_count <= '0;
    else if (out_valid && out_ready) search_count <= search_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_kd_nearest_search.sv
// Directed self-checking bench for kd_nearest_search (depth=2, three-node tree).
module tb_kd_nearest_search;

  localparam int unsigned DS = 8;
  localparam int unsigned CS = 24;
  localparam int unsigned DZ = 10;
  localparam int unsigned IS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CS-1:0] point_in;
  logic          node_rd;
  logic [IS-1:0] node_addr;
  logic [CS-1:0] node_data;
  logic          out_valid;
  logic          out_ready;
  logic [IS-1:0] best_idx;
  logic [CS-1:0] best_center;
  logic [DZ-1:0] best_dist;
`ifdef KD_SEARCH_STATS_EN
  logic [15:0]   search_count;
`endif

  logic [CS-1:0] mem [3];

  int checks = 0;
  int errors = 0;

  kd_nearest_search #(.dim(3), .data_range(255), .depth(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .point_in(point_in),
    .node_rd(node_rd),
    .node_addr(node_addr),
    .node_data(node_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .best_idx(best_idx),
    .best_center(best_center),
    .best_dist(best_dist)
`ifdef KD_SEARCH_STATS_EN
    ,
    .search_count(search_count)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle-latency node memory model
  always @(posedge clk) begin
    if (node_rd) node_data <= mem[node_addr];
  end

  function automatic logic [CS-1:0] pack(input logic [DS-1:0] x, input logic [DS-1:0] y,
                                         input logic [DS-1:0] z);
    return {z, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one query with out_ready high; check address trace, latency and result
  task automatic run_query(input string tag, input logic [CS-1:0] p, input int exp_addr1,
                           input int exp_idx, input int exp_dist, input logic [CS-1:0] exp_center);
    int lat;
    int na;
    int addrs [2];
    addrs[0] = -1;
    addrs[1] = -1;
    point_in  = p;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    na  = 0;
    while (!out_valid && lat < 20) begin
      if (node_rd && na < 2) begin
        addrs[na] = int'(node_addr);
        na++;
      end
      tick();
      lat++;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".addr0"}, 32'(addrs[0]), 32'd0);
    chk({tag, ".addr1"}, 32'(addrs[1]), 32'(exp_addr1));
    chk({tag, ".best_idx"}, 32'(best_idx), 32'(exp_idx));
    chk({tag, ".best_dist"}, 32'(best_dist), 32'(exp_dist));
    chk({tag, ".best_center"}, 32'(best_center), 32'(exp_center));
    tick();
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    point_in  = '0;
    node_data = '0;
    mem[0] = pack(8'd100, 8'd100, 8'd100);
    mem[1] = pack(8'd50,  8'd50,  8'd50);
    mem[2] = pack(8'd200, 8'd200, 8'd200);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.node_rd", 32'(node_rd), 32'd0);
    chk("rst.node_addr", 32'(node_addr), 32'd0);
    chk("rst.best_idx", 32'(best_idx), 32'd0);
    chk("rst.best_dist", 32'(best_dist), 32'd0);
    chk("rst.best_center", 32'(best_center), 32'd0);
`ifdef KD_SEARCH_STATS_EN
    chk("rst.search_count", 32'(search_count), 32'd0);
`endif

    // Basic left descent: root 120, left 30
    run_query("q60", pack(8'd60, 8'd60, 8'd60), 1, 1, 30, pack(8'd50, 8'd50, 8'd50));
    // Axis equality goes left: root 200, left 150
    run_query("q100", pack(8'd100, 8'd0, 8'd0), 1, 1, 150, pack(8'd50, 8'd50, 8'd50));
    // Tie keeps root: both at 75
    run_query("q75", pack(8'd75, 8'd75, 8'd75), 1, 0, 75, pack(8'd100, 8'd100, 8'd100));

    // Maximum distance, right descent, tie keeps root
    mem[0] = '0;
    mem[2] = '0;
    run_query("q255", pack(8'd255, 8'd255, 8'd255), 2, 0, 765, '0);
    mem[0] = pack(8'd100, 8'd100, 8'd100);
    mem[2] = pack(8'd200, 8'd200, 8'd200);

    // Backpressure: hold DONE with a competing query pending
    point_in  = pack(8'd60, 8'd60, 8'd60);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    point_in = pack(8'd200, 8'd200, 8'd200);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("bp.reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.node_rd", 32'(node_rd), 32'd0);
      chk("bp.best_idx", 32'(best_idx), 32'd1);
      chk("bp.best_dist", 32'(best_dist), 32'd30);
      chk("bp.best_center", 32'(best_center), 32'(pack(8'd50, 8'd50, 8'd50)));
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp.no_new_fetch", 32'(node_rd), 32'd0);

    // Reset during EVAL of the root discards the partial result
    point_in = pack(8'd60, 8'd60, 8'd60);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ab.fetch", 32'(node_rd), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab.out_valid", 32'(out_valid), 32'd0);
    chk("ab.in_ready", 32'(in_ready), 32'd1);
    chk("ab.node_rd", 32'(node_rd), 32'd0);
    chk("ab.best_dist", 32'(best_dist), 32'd0);
    chk("ab.best_idx", 32'(best_idx), 32'd0);
`ifdef KD_SEARCH_STATS_EN
    chk("ab.search_count", 32'(search_count), 32'd0);
`endif

    // Recovery and three completed searches; right descent: root 300, right 20
    run_query("q200", pack(8'd200, 8'd210, 8'd190), 2, 2, 20, pack(8'd200, 8'd200, 8'd200));
    run_query("q60b", pack(8'd60, 8'd60, 8'd60), 1, 1, 30, pack(8'd50, 8'd50, 8'd50));
    run_query("q75b", pack(8'd75, 8'd75, 8'd75), 1, 0, 75, pack(8'd100, 8'd100, 8'd100));
`ifdef KD_SEARCH_STATS_EN
    chk("st.search_count", 32'(search_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st.search_count_rst", 32'(search_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
